// File: rtl/mem_loader_pkg.sv
// Shared types for the boot loader: FSM state encoding and default bus width.
package mem_loader_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

endpackage

// File: rtl/mem_port_mux.sv
// Combinational selector of the exmemory port: the core owns it in RUN, the loader otherwise.
// Zero latency; core writes outside RUN are dropped here.
module mem_port_mux
  import mem_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  state_e           state_i,
  input  logic             ldr_memwrite_i,
  input  logic [WIDTH-1:0] ldr_addr_i,
  input  logic [WIDTH-1:0] ldr_writedata_i,
  input  logic             core_memwrite_i,
  input  logic [WIDTH-1:0] core_addr_i,
  input  logic [WIDTH-1:0] core_writedata_i,
  output logic             mem_memwrite_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_writedata_o
);

  logic sel_core;

  always_comb begin
    sel_core        = (state_i == ST_RUN);
    mem_memwrite_o  = ldr_memwrite_i;
    mem_addr_o      = ldr_addr_i;
    mem_writedata_o = ldr_writedata_i;
    if (sel_core) begin
      mem_memwrite_o  = core_memwrite_i;
      mem_addr_o      = core_addr_i;
      mem_writedata_o = core_writedata_i;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Boot loader: holds the MIPS core in reset, streams bytes into memory from address 0, then releases it.
// One byte per cycle, written the same cycle it is accepted; in_ready is high for the whole LOAD state.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             run,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             core_memwrite,
  input  logic [WIDTH-1:0] core_addr,
  input  logic [WIDTH-1:0] core_writedata,
  output logic             core_reset,
  output logic             mem_memwrite,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_writedata,
  output logic             busy,
  output logic             error
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_cnt_q, addr_cnt_d;
  logic             error_q, error_d;
  logic             core_reset_q, core_reset_d;
  logic             busy_q, busy_d;
  logic             accept;

  assign in_ready = (state_q == ST_LOAD);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    error_d    = error_q;
    unique case (state_q)
      ST_HOLD: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          addr_cnt_d = '0;
          error_d    = 1'b0;
        end else if (run) begin
          state_d = ST_RELEASE;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          addr_cnt_d = addr_cnt_q + 1'b1;
          if (in_last) begin
            state_d = ST_RELEASE;
          end else if (addr_cnt_q == CNT_MAX) begin
            // Image does not fit: abort back to HOLD, counter has wrapped to 0.
            state_d = ST_HOLD;
            error_d = 1'b1;
          end
        end
      end
      ST_RELEASE: state_d = ST_RUN;
      ST_RUN: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          addr_cnt_d = '0;
          error_d    = 1'b0;
        end
      end
      default: state_d = ST_HOLD;
    endcase

    // Reset drops only after a full cycle spent in RUN, so the core sees two cycles from release.
    core_reset_d = !((state_q == ST_RUN) && (state_d == ST_RUN));
    busy_d       = (state_d == ST_LOAD) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HOLD;
      addr_cnt_q   <= '0;
      error_q      <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_cnt_q   <= addr_cnt_d;
      error_q      <= error_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
    end
  end

  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign error      = error_q;

  mem_port_mux #(.WIDTH(WIDTH)) u_mux (
    .state_i          (state_q),
    .ldr_memwrite_i   (accept),
    .ldr_addr_i       (addr_cnt_q),
    .ldr_writedata_i  (in_data),
    .core_memwrite_i  (core_memwrite),
    .core_addr_i      (core_addr),
    .core_writedata_i (core_writedata),
    .mem_memwrite_o   (mem_memwrite),
    .mem_addr_o       (mem_addr),
    .mem_writedata_o  (mem_writedata)
  );

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: expected memory writes are queued when driven and popped as they appear on mem_*.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_start, run;
  logic       in_valid, in_last, in_ready;
  logic [7:0] in_data;
  logic       core_memwrite;
  logic [7:0] core_addr, core_writedata;
  logic       core_reset, mem_memwrite, busy, error;
  logic [7:0] mem_addr, mem_writedata;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] sb[$];
  logic [7:0]  tmem[256];
  logic [7:0]  exp_addr;

  always #5 clk = ~clk;

  mem_loader #(.WIDTH(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .load_start     (load_start),
    .run            (run),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .core_memwrite  (core_memwrite),
    .core_addr      (core_addr),
    .core_writedata (core_writedata),
    .core_reset     (core_reset),
    .mem_memwrite   (mem_memwrite),
    .mem_addr       (mem_addr),
    .mem_writedata  (mem_writedata),
    .busy           (busy),
    .error          (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every memory write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_memwrite === 1'b1) begin
      tmem[mem_addr] = mem_writedata;
      if (sb.size() == 0) begin
        check("extra_wr", {8'h01, mem_addr, mem_writedata}, 32'h0);
      end else begin
        check("wr", {16'h0, mem_addr, mem_writedata}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    exp_addr = 8'h00;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    check("in_ready", in_ready, 1);
    if (in_ready) begin
      sb.push_back({exp_addr, d});
      exp_addr++;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic core_wr(input logic [7:0] a, input logic [7:0] d);
    core_memwrite  = 1'b1;
    core_addr      = a;
    core_writedata = d;
    sb.push_back({a, d});
    tick();
    core_memwrite = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    check("rst_core_reset", core_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_memwrite", mem_memwrite, 0);
    reset = 1'b0;
    tick();
  endtask

  // After the releasing edge: one cycle still in reset, then core_reset drops.
  task automatic check_release(input string tag);
    check({tag, "_crst0"}, core_reset, 1);
    check({tag, "_busy0"}, busy, 1);
    tick();
    check({tag, "_crst1"}, core_reset, 1);
    check({tag, "_busy1"}, busy, 0);
    tick();
    check({tag, "_crst2"}, core_reset, 0);
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; run = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    core_memwrite = 1'b1; core_addr = 8'h44; core_writedata = 8'h99;
    exp_addr = 8'h00;
    #2;
    check("init_memwrite", mem_memwrite, 0);
    core_memwrite = 1'b0;
    do_reset();

    // Basic 4-byte image, then run.
    pulse_load();
    check("ld_busy", busy, 1);
    check("ld_core_reset", core_reset, 1);
    send_byte(8'h20, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b1);
    check("ld_in_ready_after", in_ready, 0);
    check_release("t1");
    check("word0", {tmem[3], tmem[2], tmem[1], tmem[0]}, 32'h05000220);
    core_addr = 8'h33;
    #1;
    check("run_mux_addr", mem_addr, 8'h33);
    core_wr(8'd76, 8'd7);

    // Run without loading.
    do_reset();
    pulse_run();
    check_release("t2");
    core_wr(8'd76, 8'd7);
    core_wr(8'd80, 8'hC3);

    // Backpressure: gaps of two idle cycles between bytes.
    do_reset();
    pulse_load();
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hA0 + 8'(i), i == 2);
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          check("gap_addr", mem_addr, exp_addr);
          tick();
        end
      end
    end
    check("bp_a0", tmem[0], 8'hA0);
    check("bp_a2", tmem[2], 8'hA2);

    // Overflow: 256 bytes without in_last.
    do_reset();
    pulse_load();
    for (int i = 0; i < 256; i++) send_byte(8'(i) ^ 8'h5A, 1'b0);
    check("ovf_error", error, 1);
    check("ovf_busy", busy, 0);
    check("ovf_in_ready", in_ready, 0);
    check("ovf_addr_wrap", mem_addr, 0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) tick();
    in_valid = 1'b0;
    check("ovf_core_reset", core_reset, 1);
    check("ovf_error_sticky", error, 1);
    pulse_load();
    check("ovf_error_clr", error, 0);
    send_byte(8'h11, 1'b1);
    check_release("t4");

    // Reload from RUN; core writes are dropped once LOAD begins.
    core_wr(8'h10, 8'hAA);
    pulse_load();
    check("reload_core_reset", core_reset, 1);
    check("reload_busy", busy, 1);
    core_memwrite = 1'b1; core_addr = 8'h90; core_writedata = 8'h55;
    #1;
    check("reload_drop", mem_memwrite, 0);
    tick();
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b1);
    core_memwrite = 1'b0;
    check("reload_a0", tmem[0], 8'h61);
    check("reload_a1", tmem[1], 8'h62);
    tick();
    tick();

    // Reset in the middle of a load.
    do_reset();
    pulse_load();
    send_byte(8'h71, 1'b0);
    send_byte(8'h72, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h73;
    reset    = 1'b1;
    #1;
    check("mid_rst_memwrite", mem_memwrite, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_core_reset", core_reset, 1);
    check("mid_rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    reset    = 1'b0;
    tick();
    pulse_load();
    send_byte(8'h81, 1'b0);
    send_byte(8'h82, 1'b1);
    check("fresh_a0", tmem[0], 8'h81);
    check("fresh_a1", tmem[1], 8'h82);
    tick();
    tick();

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
